// File: rtl/ahb3lite_pkg.sv
// ----------------------------------------------------------------------------
// ahb3lite_pkg
//   Shared AHB3-Lite encodings and the master-port FSM state type.
//   No ports; imported by the interconnect master port and its decoder.
// ----------------------------------------------------------------------------
package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Master-port FSM. Encoding is visible on the dbg_state output.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,  // no data phase outstanding towards a slave
    ST_ACCESS = 3'd1,  // data phase in progress with a slave port
    ST_WAIT   = 3'd2,  // address phase held, target arbiter not granted yet
    ST_ERR1   = 3'd3,  // first cycle of the two-cycle ERROR response
    ST_ERR2   = 3'd4   // second cycle of the two-cycle ERROR response
  } mp_state_t;

  // NONSEQ and SEQ carry a real transfer; IDLE and BUSY do not.
  function automatic logic is_transfer(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb3lite_interconnect_addr_decoder.sv
// ----------------------------------------------------------------------------
// ahb3lite_interconnect_addr_decoder
//   Combinational address decode. Region s hits when the masked address bits
//   equal the masked base. Overlapping regions resolve to the lowest index.
// Ports
//   haddr  in   address to decode
//   mask   in   per-region mask
//   base   in   per-region base
//   sel    out  one-hot selected region (all zero when unmapped)
//   idx    out  binary index of the selected region (0 when unmapped)
//   hit    out  at least one region matched
// ----------------------------------------------------------------------------
module ahb3lite_interconnect_addr_decoder #(
  parameter  int HADDR_SIZE = 32,
  parameter  int SLAVES     = 8,
  localparam int IDX_W      = (SLAVES > 1) ? $clog2(SLAVES) : 1
) (
  input  logic [HADDR_SIZE-1:0] haddr,
  input  logic [HADDR_SIZE-1:0] mask [SLAVES],
  input  logic [HADDR_SIZE-1:0] base [SLAVES],
  output logic [SLAVES-1:0]     sel,
  output logic [IDX_W-1:0]      idx,
  output logic                  hit
);

  always_comb begin
    sel = '0;
    idx = '0;
    hit = 1'b0;
    // Walk from the top down so the lowest matching index is the last write.
    for (int s = SLAVES - 1; s >= 0; s--) begin
      if (((haddr ^ base[s]) & mask[s]) == '0) begin
        hit = 1'b1;
        idx = IDX_W'(s);
      end
    end
    if (hit) sel = SLAVES'(1) << idx;
  end

endmodule

// File: rtl/ahb3lite_interconnect_master_port.sv
// ----------------------------------------------------------------------------
// ahb3lite_interconnect_master_port
//   Per-master front end of the AHB3-Lite multi-layer switch. Decodes the
//   master address into a one-hot slave request, fans the address phase out
//   to every slave-port arbiter, holds the address phase while the target
//   arbiter has not granted this master, and muxes the data-phase response
//   back. Unmapped transfers receive a two-cycle ERROR response.
// Ports
//   HRESETn/HCLK          async active-low reset, clock
//   mst_priority          master priority, forwarded as slv_priority
//   mst_H*                master address/data phase; mst_HREADY = bus HREADY
//   mst_HREADYOUT/HRDATA/HRESP   response to the master
//   slv_HADDRmask/base    address map, one region per slave port
//   slv_HSEL              one-hot request to the slave-port arbiters
//   slv_H*                shared address/data phase to all slave ports
//   slv_HREADY            local HREADY (equals mst_HREADYOUT)
//   slv_HRDATA/HREADYOUT/HRESP   per-slave-port response
//   slv_granted           slave port s currently grants this master
//   can_switch            slave port s may re-arbitrate away from this master
//   dbg_state             current FSM state (mp_state_t encoding)
//
// Handshake: an address phase is accepted from the master on a rising edge
// where mst_HSEL & mst_HREADY & HTRANS in {NONSEQ,SEQ}. A data phase
// completes on an edge where mst_HREADYOUT is 1. A held address phase is
// handed to a slave on the edge where its arbiter grants us and that slave
// port reports HREADYOUT=1; the slave's data phase starts on the next cycle.
// ----------------------------------------------------------------------------
module ahb3lite_interconnect_master_port
  import ahb3lite_pkg::*;
#(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int SLAVES     = 8
) (
  input  logic                  HRESETn,
  input  logic                  HCLK,

  input  logic [2:0]            mst_priority,
  input  logic                  mst_HSEL,
  input  logic [HADDR_SIZE-1:0] mst_HADDR,
  input  logic [HDATA_SIZE-1:0] mst_HWDATA,
  input  logic                  mst_HWRITE,
  input  logic [2:0]            mst_HSIZE,
  input  logic [2:0]            mst_HBURST,
  input  logic [3:0]            mst_HPROT,
  input  logic [1:0]            mst_HTRANS,
  input  logic                  mst_HMASTLOCK,
  input  logic                  mst_HREADY,
  output logic                  mst_HREADYOUT,
  output logic [HDATA_SIZE-1:0] mst_HRDATA,
  output logic                  mst_HRESP,

  input  logic [HADDR_SIZE-1:0] slv_HADDRmask [SLAVES],
  input  logic [HADDR_SIZE-1:0] slv_HADDRbase [SLAVES],

  output logic [SLAVES-1:0]     slv_HSEL,
  output logic [2:0]            slv_priority,
  output logic [HADDR_SIZE-1:0] slv_HADDR,
  output logic [HDATA_SIZE-1:0] slv_HWDATA,
  output logic                  slv_HWRITE,
  output logic [2:0]            slv_HSIZE,
  output logic [2:0]            slv_HBURST,
  output logic [3:0]            slv_HPROT,
  output logic [1:0]            slv_HTRANS,
  output logic                  slv_HMASTLOCK,
  output logic                  slv_HREADY,

  input  logic [HDATA_SIZE-1:0] slv_HRDATA [SLAVES],
  input  logic [SLAVES-1:0]     slv_HREADYOUT,
  input  logic [SLAVES-1:0]     slv_HRESP,
  input  logic [SLAVES-1:0]     slv_granted,
  output logic [SLAVES-1:0]     can_switch,

  output logic [2:0]            dbg_state
);

  localparam int IDX_W = (SLAVES > 1) ? $clog2(SLAVES) : 1;

  mp_state_t             state_q, state_d;
  logic [IDX_W-1:0]      dp_idx_q, dp_idx_d;
  logic [HADDR_SIZE-1:0] hold_haddr_q, hold_haddr_d;
  logic                  hold_hwrite_q, hold_hwrite_d;
  logic [2:0]            hold_hsize_q, hold_hsize_d;
  logic [2:0]            hold_hburst_q, hold_hburst_d;
  logic [3:0]            hold_hprot_q, hold_hprot_d;
  logic [1:0]            hold_htrans_q, hold_htrans_d;
  logic                  hold_hmastlock_q, hold_hmastlock_d;

  // The hold register is only meaningful while stalled in WAIT.
  logic hold_valid;
  assign hold_valid = (state_q == ST_WAIT);

  // Address phase as presented to the slave ports: held copy or live master.
  logic [HADDR_SIZE-1:0] ap_haddr;
  logic                  ap_hwrite, ap_hmastlock, ap_hsel, ap_req;
  logic [2:0]            ap_hsize, ap_hburst;
  logic [3:0]            ap_hprot;
  logic [1:0]            ap_htrans;

  always_comb begin
    ap_haddr     = mst_HADDR;
    ap_hwrite    = mst_HWRITE;
    ap_hsize     = mst_HSIZE;
    ap_hburst    = mst_HBURST;
    ap_hprot     = mst_HPROT;
    ap_htrans    = mst_HTRANS;
    ap_hmastlock = mst_HMASTLOCK;
    ap_hsel      = mst_HSEL;
    ap_req       = mst_HSEL & mst_HREADY & is_transfer(mst_HTRANS);
    if (hold_valid) begin
      ap_haddr     = hold_haddr_q;
      ap_hwrite    = hold_hwrite_q;
      ap_hsize     = hold_hsize_q;
      ap_hburst    = hold_hburst_q;
      ap_hprot     = hold_hprot_q;
      // The slave never saw the preceding beat from us, so it must start fresh.
      ap_htrans    = (hold_htrans_q == HTRANS_SEQ) ? HTRANS_NONSEQ : hold_htrans_q;
      ap_hmastlock = hold_hmastlock_q;
      ap_hsel      = 1'b1;
      ap_req       = 1'b1;
    end
  end

  logic [SLAVES-1:0] dec_sel;
  logic [IDX_W-1:0]  dec_idx;
  logic              dec_hit;

  ahb3lite_interconnect_addr_decoder #(
    .HADDR_SIZE (HADDR_SIZE),
    .SLAVES     (SLAVES)
  ) u_decoder (
    .haddr (ap_haddr),
    .mask  (slv_HADDRmask),
    .base  (slv_HADDRbase),
    .sel   (dec_sel),
    .idx   (dec_idx),
    .hit   (dec_hit)
  );

  logic in_err, tgt_granted, tgt_ready;
  assign in_err      = (state_q == ST_ERR1) || (state_q == ST_ERR2);
  assign tgt_granted = |(dec_sel & slv_granted);
  assign tgt_ready   = |(dec_sel & slv_HREADYOUT);

  always_comb begin
    state_d          = state_q;
    dp_idx_d         = dp_idx_q;
    hold_haddr_d     = hold_haddr_q;
    hold_hwrite_d    = hold_hwrite_q;
    hold_hsize_d     = hold_hsize_q;
    hold_hburst_d    = hold_hburst_q;
    hold_hprot_d     = hold_hprot_q;
    hold_htrans_d    = hold_htrans_q;
    hold_hmastlock_d = hold_hmastlock_q;

    case (state_q)
      ST_ERR1: state_d = ST_ERR2;
      ST_WAIT: begin
        if (tgt_granted && tgt_ready) begin
          state_d  = ST_ACCESS;
          dp_idx_d = dec_idx;
        end
      end
      default: begin  // ST_IDLE, ST_ACCESS, ST_ERR2
        if (state_q == ST_ERR2) state_d = ST_IDLE;
        if (mst_HREADY) begin
          state_d = ST_IDLE;
          if (ap_req) begin
            if (!dec_hit) begin
              state_d = ST_ERR1;
            end else if (tgt_granted && !in_err) begin
              state_d  = ST_ACCESS;
              dp_idx_d = dec_idx;
            end else begin
              // Accept from the master now, present to the slave once granted.
              state_d          = ST_WAIT;
              hold_haddr_d     = mst_HADDR;
              hold_hwrite_d    = mst_HWRITE;
              hold_hsize_d     = mst_HSIZE;
              hold_hburst_d    = mst_HBURST;
              hold_hprot_d     = mst_HPROT;
              hold_htrans_d    = mst_HTRANS;
              hold_hmastlock_d = mst_HMASTLOCK;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q          <= ST_IDLE;
      dp_idx_q         <= '0;
      hold_haddr_q     <= '0;
      hold_hwrite_q    <= 1'b0;
      hold_hsize_q     <= '0;
      hold_hburst_q    <= '0;
      hold_hprot_q     <= '0;
      hold_htrans_q    <= HTRANS_IDLE;
      hold_hmastlock_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      dp_idx_q         <= dp_idx_d;
      hold_haddr_q     <= hold_haddr_d;
      hold_hwrite_q    <= hold_hwrite_d;
      hold_hsize_q     <= hold_hsize_d;
      hold_hburst_q    <= hold_hburst_d;
      hold_hprot_q     <= hold_hprot_d;
      hold_htrans_q    <= hold_htrans_d;
      hold_hmastlock_q <= hold_hmastlock_d;
    end
  end

  // Response path towards the master.
  always_comb begin
    mst_HREADYOUT = 1'b1;
    mst_HRESP     = HRESP_OKAY;
    mst_HRDATA    = '0;
    case (state_q)
      ST_ERR1: begin
        mst_HREADYOUT = 1'b0;
        mst_HRESP     = HRESP_ERROR;
      end
      ST_ERR2: mst_HRESP = HRESP_ERROR;
      ST_WAIT: mst_HREADYOUT = 1'b0;
      ST_ACCESS: begin
        mst_HREADYOUT = slv_HREADYOUT[dp_idx_q];
        mst_HRESP     = slv_HRESP[dp_idx_q];
        mst_HRDATA    = slv_HRDATA[dp_idx_q];
      end
      default: ;
    endcase
  end

  // A locked transfer or a burst continuation must keep the arbiter on us.
  logic keep_grant;
  assign keep_grant = ap_hsel & dec_hit &
                      (ap_hmastlock | (ap_htrans == HTRANS_SEQ) | (ap_htrans == HTRANS_BUSY));

  assign slv_HSEL      = (ap_req && dec_hit && !in_err) ? dec_sel : '0;
  assign can_switch    = keep_grant ? ~dec_sel : '1;
  assign slv_priority  = mst_priority;
  assign slv_HADDR     = ap_haddr;
  assign slv_HWDATA    = mst_HWDATA;
  assign slv_HWRITE    = ap_hwrite;
  assign slv_HSIZE     = ap_hsize;
  assign slv_HBURST    = ap_hburst;
  assign slv_HPROT     = ap_hprot;
  assign slv_HTRANS    = ap_htrans;
  assign slv_HMASTLOCK = ap_hmastlock;
  assign slv_HREADY    = mst_HREADYOUT;
  assign dbg_state     = state_q;

endmodule
